mips_multicycle_ctrl: RTL and testbench

Main control unit for the multicycle MIPS datapath under `top`. It sequences one instruction over 3–5 cycles: fetch, decode, address/execute, memory, and writeback. It drives every mux select and write enable in the datapath, and stalls on a shared-memory ready handshake. It replaces the single-cycle combinational controller so that one memory port and one ALU serve both instruction fetch and data access.

---
 rtl/mips_ctrl_pkg.sv | 72 +++++++
 rtl/mips_aludec.sv | 29 ++
 rtl/mips_multicycle_ctrl.sv | 98 +++++++++
 tb/tb_mips_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/funct codes, ALU encodings, FSM states and the per-state
// control word for the multicycle MIPS controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef logic [1:0] aluop_t;
  localparam aluop_t ALUOP_ADD   = 2'b00;
  localparam aluop_t ALUOP_SUB   = 2'b01;
  localparam aluop_t ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic       branch;
    logic       iord;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    aluop_t     aluOp;
  } ctrl_t;

  // Moore decode: the control word each state presents before any gating.
  function automatic ctrl_t stateCtrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.memReq = 1'b1; c.irWrite = 1'b1; c.pcWrite = 1'b1; c.aluSrcB = 2'b01; end
      DECODE:   c.aluSrcB = 2'b11;
      MEMADR:   begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      MEMREAD:  begin c.iord = 1'b1; c.memReq = 1'b1; end
      MEMWB:    begin c.memToReg = 1'b1; c.regWrite = 1'b1; end
      MEMWRITE: begin c.iord = 1'b1; c.memReq = 1'b1; c.memWrite = 1'b1; end
      EXECUTE:  begin c.aluSrcA = 1'b1; c.aluOp = ALUOP_FUNCT; end
      ALUWB:    begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      BRANCH:   begin c.aluSrcA = 1'b1; c.aluOp = ALUOP_SUB; c.pcSrc = 2'b01; c.branch = 1'b1; end
      ADDIEX:   begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      ADDIWB:   c.regWrite = 1'b1;
      JUMP:     begin c.pcSrc = 2'b10; c.pcWrite = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_aludec.sv
// Combinational ALU decoder: picks the ALU operation from aluop and,
// for R-type instructions, from the funct field.
module mips_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/
// writeback and stalls memory states on the shared-memory ready handshake.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   memReady;
  logic   opSupported;
  logic   pcWriteNow;

  assign memReady = WAIT_MEM ? mem_ready : 1'b1;

  always_comb begin
    opSupported = 1'b1;
    state_d     = state_q;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: opSupported = 1'b1;
      default:                                       opSupported = 1'b0;
    endcase
    case (state_q)
      FETCH:    state_d = memReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = memReady ? MEMWB : MEMREAD;
      MEMWRITE: state_d = memReady ? FETCH : MEMWRITE;
      EXECUTE:  state_d = ALUWB;
      ADDIEX:   state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  // The control word is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      ctrl_q  <= stateCtrl(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= stateCtrl(state_d);
    end
  end

  // Only the fetch PC increment waits on memory; the jump write does not.
  assign pcWriteNow = ctrl_q.pcWrite & (~ctrl_q.irWrite | memReady);

  assign mem_req    = reset & ctrl_q.memReq;
  assign memwrite   = reset & ctrl_q.memWrite;
  assign irwrite    = reset & ctrl_q.irWrite & memReady;
  assign pcen       = reset & (pcWriteNow | (ctrl_q.branch & zero));
  assign regwrite   = reset & ctrl_q.regWrite;
  assign iord       = ctrl_q.iord;
  assign regdst     = ctrl_q.regDst;
  assign memtoreg   = ctrl_q.memToReg;
  assign alusrca    = ctrl_q.aluSrcA;
  assign alusrcb    = ctrl_q.aluSrcB;
  assign pcsrc      = ctrl_q.pcSrc;
  assign illegal_op = reset & (state_q == DECODE) & ~opSupported;

  mips_aludec u_aludec (
    .aluop_i      (ctrl_q.aluOp),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: each driven cycle queues the
// hand-derived output vector, a negedge monitor pops and compares it.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       irWrite;
    logic       pcEn;
    logic       regWrite;
    logic       iord;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [2:0] aluControl;
    logic       illegal;
  } outVec_t;

  typedef struct {
    outVec_t v;
    string   name;
  } expEntry_t;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, irwrite, pcen, regwrite, iord, regdst, memtoreg, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  expEntry_t expQ[$];
  int        compared;
  int        mismatched;
  int        cycleNo;

  logic [5:0] instrOp;
  logic [5:0] instrFunct;
  logic [2:0] expAluExec;
  logic       expIll;

  mips_multicycle_ctrl #(.WAIT_MEM(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .iord       (iord),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle spent in the named state.
  function automatic outVec_t expFor(input string st, input logic rdy, input logic z, input logic rst);
    outVec_t v;
    v = '0;
    v.aluControl = 3'b010;
    case (st)
      "FETCH":    begin v.memReq = 1'b1; v.irWrite = rdy; v.pcEn = rdy; v.aluSrcB = 2'b01; end
      "DECODE":   begin v.aluSrcB = 2'b11; v.illegal = expIll; end
      "MEMADR":   begin v.aluSrcA = 1'b1; v.aluSrcB = 2'b10; end
      "MEMREAD":  begin v.iord = 1'b1; v.memReq = 1'b1; end
      "MEMWB":    begin v.memToReg = 1'b1; v.regWrite = 1'b1; end
      "MEMWRITE": begin v.iord = 1'b1; v.memReq = 1'b1; v.memWrite = 1'b1; end
      "EXECUTE":  begin v.aluSrcA = 1'b1; v.aluControl = expAluExec; end
      "ALUWB":    begin v.regDst = 1'b1; v.regWrite = 1'b1; end
      "BRANCH":   begin v.aluSrcA = 1'b1; v.pcSrc = 2'b01; v.aluControl = 3'b110; v.pcEn = z; end
      "ADDIEX":   begin v.aluSrcA = 1'b1; v.aluSrcB = 2'b10; end
      "ADDIWB":   v.regWrite = 1'b1;
      "JUMP":     begin v.pcSrc = 2'b10; v.pcEn = 1'b1; end
      default:    v = '1;
    endcase
    if (!rst) begin
      v.memReq = 1'b0; v.memWrite = 1'b0; v.irWrite = 1'b0;
      v.pcEn = 1'b0; v.regWrite = 1'b0; v.illegal = 1'b0;
    end
    return v;
  endfunction

  task automatic startInstr(input logic [5:0] o, input logic [5:0] f, input logic [2:0] alu, input logic ill);
    instrOp    = o;
    instrFunct = f;
    expAluExec = alu;
    expIll     = ill;
  endtask

  task automatic applyStimulus(input string st, input logic rdy, input logic z, input logic rst);
    expEntry_t e;
    @(posedge clk);
    #1;
    op        = instrOp;
    funct     = instrFunct;
    mem_ready = rdy;
    zero      = z;
    reset     = rst;
    cycleNo++;
    e.v    = expFor(st, rdy, z, rst);
    e.name = $sformatf("%s@cyc%0d", st, cycleNo);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expEntry_t e);
    outVec_t act;
    act = {mem_req, memwrite, irwrite, pcen, regwrite, iord, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op};
    compared++;
    if (act !== e.v) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%b required=%b", e.name, act, e.v);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  logic [5:0] rFunct[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h3F};
  logic [2:0] rAlu[5]   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010};

  initial begin
    compared = 0; mismatched = 0; cycleNo = 0;
    reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    startInstr(6'h00, 6'h00, 3'b010, 1'b0);
    applyStimulus("FETCH", 1, 0, 0);
    applyStimulus("FETCH", 1, 0, 0);

    startInstr(6'h23, 6'h00, 3'b010, 1'b0);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("MEMADR", 1, 0, 1);
    applyStimulus("MEMREAD", 1, 0, 1);
    applyStimulus("MEMWB", 1, 0, 1);

    startInstr(6'h00, 6'h2A, 3'b111, 1'b0);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("EXECUTE", 1, 0, 1);
    applyStimulus("ALUWB", 1, 0, 1);

    // mem_ready low outside memory states must not stall anything
    for (int i = 0; i < 5; i++) begin
      startInstr(6'h00, rFunct[i], rAlu[i], 1'b0);
      applyStimulus("FETCH", 1, 0, 1);
      applyStimulus("DECODE", 0, 1, 1);
      applyStimulus("EXECUTE", 0, 1, 1);
      applyStimulus("ALUWB", 0, 0, 1);
    end

    startInstr(6'h04, 6'h00, 3'b010, 1'b0);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("BRANCH", 1, 1, 1);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("BRANCH", 1, 0, 1);

    startInstr(6'h2B, 6'h00, 3'b010, 1'b0);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("MEMADR", 1, 0, 1);
    applyStimulus("MEMWRITE", 0, 0, 1);
    applyStimulus("MEMWRITE", 0, 0, 1);
    applyStimulus("MEMWRITE", 0, 0, 1);
    applyStimulus("MEMWRITE", 1, 0, 1);

    startInstr(6'h08, 6'h00, 3'b010, 1'b0);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("ADDIEX", 1, 0, 1);
    applyStimulus("ADDIWB", 1, 0, 1);

    startInstr(6'h02, 6'h00, 3'b010, 1'b0);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("JUMP", 1, 0, 1);

    startInstr(6'h3F, 6'h00, 3'b010, 1'b1);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);

    startInstr(6'h23, 6'h00, 3'b010, 1'b0);
    applyStimulus("FETCH", 0, 0, 1);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("MEMADR", 1, 0, 1);
    applyStimulus("MEMREAD", 0, 0, 1);
    applyStimulus("MEMREAD", 1, 0, 1);
    applyStimulus("MEMWB", 1, 0, 1);

    // reset arriving in MEMWB, then again in a stalled MEMWRITE
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("MEMADR", 1, 0, 1);
    applyStimulus("MEMREAD", 1, 0, 1);
    applyStimulus("MEMWB", 1, 0, 0);
    applyStimulus("FETCH", 1, 0, 0);
    applyStimulus("FETCH", 1, 0, 0);

    startInstr(6'h2B, 6'h00, 3'b010, 1'b0);
    applyStimulus("FETCH", 1, 0, 1);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("MEMADR", 1, 0, 1);
    applyStimulus("MEMWRITE", 0, 0, 0);
    applyStimulus("FETCH", 1, 0, 1);

    startInstr(6'h02, 6'h00, 3'b010, 1'b0);
    applyStimulus("DECODE", 1, 0, 1);
    applyStimulus("JUMP", 1, 0, 1);
    applyStimulus("FETCH", 1, 0, 1);

    repeat (3) @(negedge clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: actual=%0d pending required=0 pending", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
